// File: rtl/ram_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_pkg
//  Purpose  : Shared size encodings, FSM states and width defaults for the
//             ram_port_ctrl block.
//  Revision : 1.0  initial release
// ============================================================================
package ram_port_pkg;

    localparam int C_ADDR_W = 10;
    localparam int C_DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD     = 2'd1,
        ST_RMW_RD = 2'd2,
        ST_RMW_WR = 2'd3
    } state_t;

    // Lane offset actually used: word accesses are forced aligned, halves to an even byte.
    function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] off);
        if (size[1])
            return 2'b00;
        else if (size == SZ_HALF)
            return {off[1], 1'b0};
        else
            return off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_if
//  Purpose  : Request, response and RAM-side signal bundle of ram_port_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface ram_port_if
    import ram_port_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int DATA_W = C_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    // Master is the load/store stage plus the RAM itself.
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ram_we, ram_addr, ram_din,
        output ram_dout
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ram_we, ram_addr, ram_din,
        input  ram_dout
    );

endinterface
`default_nettype wire

// File: rtl/ram_lane_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ram_lane_unit
//  Purpose  : Combinational little-endian lane extract/extend for loads and
//             byte/half merge for read-modify-write stores.
//  Revision : 1.0  initial release
// ============================================================================
module ram_lane_unit
    import ram_port_pkg::*;
#(
    parameter int DATA_W = C_DATA_W
) (
    input  wire logic [DATA_W-1:0] i_word,
    input  wire logic [1:0]        i_size,
    input  wire logic              i_signed,
    input  wire logic [1:0]        i_off,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_load,
    output logic      [DATA_W-1:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_word[{i_off[1], 4'b0000} +: 16];

        case (i_size)
            SZ_BYTE: o_load = {{(DATA_W-8){i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load = {{(DATA_W-16){i_signed & w_half[15]}}, w_half};
            default: o_load = i_word;
        endcase

        o_merged = i_word;
        case (i_size)
            SZ_BYTE: o_merged[{i_off, 3'b000} +: 8]     = i_wdata[7:0];
            SZ_HALF: o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merged = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_ctrl
//  Purpose  : Byte-addressed load/store front end for the 1024x32 data RAM,
//             with sub-word extract and read-modify-write stores.
//             Optional: RAM_PORT_MISALIGN_TRAP_EN traps misaligned half/word.
//  Revision : 1.0  initial release
// ============================================================================
module ram_port_ctrl
    import ram_port_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int DATA_W = C_DATA_W
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    ram_port_if.slave   bus
);

    state_t            r_state, w_state_nxt;
    logic              r_ram_we, w_ram_we_nxt;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
    logic [DATA_W-1:0] r_ram_din, w_ram_din_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_rsp_err, w_rsp_err_nxt;

    logic [1:0]        r_size, w_size_nxt;
    logic [1:0]        r_off, w_off_nxt;
    logic              r_signed, w_signed_nxt;
    logic              r_trap, w_trap_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_misalign;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_merged;
    logic              w_unused_addr;

    // A word store completes from IDLE; the pending write blocks a new accept for that cycle.
    assign w_req_ready   = (r_state == ST_IDLE) && !r_ram_we;
    assign w_accept      = bus.req_valid && w_req_ready;
    assign w_unused_addr = &{1'b0, bus.req_addr[31:ADDR_W+2]};

`ifdef RAM_PORT_MISALIGN_TRAP_EN
    assign w_misalign = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    ram_lane_unit #(.DATA_W(DATA_W)) u_lane (
        .i_word   (bus.ram_dout),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_off    (r_off),
        .i_wdata  (r_wdata),
        .o_load   (w_load_data),
        .o_merged (w_merged)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_ram_we_nxt    = 1'b0;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_din_nxt   = r_ram_din;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = 1'b0;
        w_size_nxt      = r_size;
        w_off_nxt       = r_off;
        w_signed_nxt    = r_signed;
        w_trap_nxt      = r_trap;
        w_wdata_nxt     = r_wdata;

        case (r_state)
            ST_IDLE: begin
                if (r_ram_we) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end else if (w_accept) begin
                    w_size_nxt   = bus.req_size;
                    w_off_nxt    = eff_offset(bus.req_size, bus.req_addr[1:0]);
                    w_signed_nxt = bus.req_signed;
                    w_wdata_nxt  = bus.req_wdata;
                    w_trap_nxt   = w_misalign;
                    if (w_misalign) begin
                        // Trapped access answers through RD without touching the RAM.
                        w_state_nxt = ST_RD;
                    end else begin
                        w_ram_addr_nxt = bus.req_addr[ADDR_W+1:2];
                        if (!bus.req_we) begin
                            w_state_nxt = ST_RD;
                        end else if (!bus.req_size[1]) begin
                            w_state_nxt = ST_RMW_RD;
                        end else begin
                            w_ram_we_nxt  = 1'b1;
                            w_ram_din_nxt = bus.req_wdata;
                        end
                    end
                end
            end
            ST_RD: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_rdata_nxt = r_trap ? '0 : w_load_data;
                w_rsp_err_nxt   = r_trap;
                w_state_nxt     = ST_IDLE;
            end
            ST_RMW_RD: begin
                w_ram_din_nxt = w_merged;
                w_ram_we_nxt  = 1'b1;
                w_state_nxt   = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_rdata_nxt = '0;
                w_state_nxt     = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_size      <= SZ_BYTE;
            r_off       <= 2'b00;
            r_signed    <= 1'b0;
            r_trap      <= 1'b0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_din   <= w_ram_din_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_size      <= w_size_nxt;
            r_off       <= w_off_nxt;
            r_signed    <= w_signed_nxt;
            r_trap      <= w_trap_nxt;
            r_wdata     <= w_wdata_nxt;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_din   = r_ram_din;

endmodule
`default_nettype wire
